// File: rtl/fht_ctrl_pkg.sv
// fht_ctrl_pkg: shared types and helpers for the FHT sequencing controller (stall option: FHT_CTRL_STALL_EN)
package fht_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_e;
  function automatic int stages_of(input int log_n);
    return log_n - 1;
  endfunction
  function automatic int a_bit_of(input int log_n);
    return log_n - 2;
  endfunction
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (i < w) begin
        r = {r[14:0], v[0]};
        v = v >> 1;
      end
    return r;
  endfunction
endpackage

// File: rtl/fht_addr_delay.sv
// fht_addr_delay: DEPTH-stage delay line for four bank addresses plus a valid bit
module fht_addr_delay #(
  parameter int DEPTH = 4,
  parameter int A_BIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [4*A_BIT-1:0] d,
  input  logic               v_in,
  output logic [4*A_BIT-1:0] q,
  output logic               v_out
);
  localparam int W = 4 * A_BIT + 1;
  localparam int L = DEPTH * W;
  logic [L-1:0] pipe_q, pipe_d;
  assign {v_out, q} = pipe_q[L-1 -: W];
  // newest entry enters at the bottom, oldest leaves at the top
  always_comb pipe_d = en ? L'({pipe_q, v_in, d}) : pipe_q;
  // shift register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pipe_q <= '0;
    else pipe_q <= pipe_d;
endmodule

// File: rtl/fht_seq_ctrl.sv
// fht_seq_ctrl: FHT read/write/coef address and stage sequencer; FHT_CTRL_STALL_EN adds the iSTALL freeze input
module fht_seq_ctrl
  import fht_ctrl_pkg::*;
#(
  parameter int LOG_N = 10,
  parameter int PIPE_LAT = 4,
  localparam int A_BIT = a_bit_of(LOG_N),
  localparam int STAGES = stages_of(LOG_N),
  localparam int SW = $clog2(STAGES)
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
`ifdef FHT_CTRL_STALL_EN
  input  logic             iSTALL,
`endif
  output logic [A_BIT-1:0] oADDR_RD_0,
  output logic [A_BIT-1:0] oADDR_RD_1,
  output logic [A_BIT-1:0] oADDR_RD_2,
  output logic [A_BIT-1:0] oADDR_RD_3,
  output logic [A_BIT-1:0] oADDR_WR_0,
  output logic [A_BIT-1:0] oADDR_WR_1,
  output logic [A_BIT-1:0] oADDR_WR_2,
  output logic [A_BIT-1:0] oADDR_WR_3,
  output logic [A_BIT-1:0] oADDR_COEF,
  output logic [SW-1:0]    oSTAGE,
  output logic             oST_ZERO,
  output logic             oST_LAST,
  output logic             oEOF_READ,
  output logic             oWE_A,
  output logic             oWE_B,
  output logic             oSOURCE_DATA,
  output logic             oSOURCE_CONT,
  output logic             oRDY
);
  localparam logic [A_BIT-1:0] KMAX = '1;
  localparam logic [SW-1:0] SLAST = SW'(STAGES - 1);
  localparam logic [4:0] DLAST = 5'(PIPE_LAT - 1);
  state_e state_q, state_d;
  logic [A_BIT-1:0] k_q, k_d, coef_q, coef_d, lo, hi;
  logic [SW-1:0] stage_q, stage_d;
  logic [4:0] drn_q, drn_d;
  logic [3:0][A_BIT-1:0] rd_q, rd_d, wr_q, wr_d, dl_addr;
  logic stall, rd_v, dl_v, busy_d;
  logic we_a_q, we_a_d, we_b_q, we_b_d, eof_q, eof_d;
  logic zero_q, zero_d, last_q, last_d, rdy_q, rdy_d;
`ifdef FHT_CTRL_STALL_EN
  assign stall = iSTALL && state_q != S_IDLE;
`else
  assign stall = 1'b0;
`endif
  // FSM: READ walks k over one bank, DRAIN waits for the write pipeline before the next stage
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    stage_d = stage_q;
    drn_d = drn_q;
    if (!stall)
      case (state_q)
        S_IDLE:
          if (iSTART) begin
            state_d = S_READ;
            k_d = '0;
            stage_d = '0;
          end
        S_READ: begin
          k_d = k_q + 1'b1;
          if (k_q == KMAX) begin
            state_d = S_DRAIN;
            drn_d = '0;
          end
        end
        default: begin
          drn_d = drn_q + 1'b1;
          if (drn_q == DLAST) begin
            state_d = stage_q == SLAST ? S_IDLE : S_READ;
            stage_d = stage_q == SLAST ? '0 : stage_q + 1'b1;
            k_d = '0;
            drn_d = '0;
          end
        end
      endcase
  end
  // outputs decoded from the next state so they line up with the state registers
  always_comb begin
    rd_v = state_d == S_READ;
    lo = stage_d == '0 ? A_BIT'(bitrev(16'(k_d), A_BIT)) : k_d;
    hi = stage_d == '0 ? lo : k_d ^ (A_BIT'(1) << ((int'(stage_d) + A_BIT - 1) % A_BIT));
    rd_d = rd_v ? {hi, hi, lo, lo} : '0;
    coef_d = rd_v && stage_d != '0 ? k_d << (STAGES - 1 - int'(stage_d)) : '0;
    eof_d = !stall && rd_v && k_d == KMAX;
    busy_d = state_d != S_IDLE;
    zero_d = busy_d && stage_d == '0;
    last_d = busy_d && stage_d == SLAST;
    rdy_d = !busy_d;
    wr_d = stall ? wr_q : dl_addr;
    we_a_d = !stall && dl_v && stage_q[0];
    we_b_d = !stall && dl_v && !stage_q[0];
  end
  // one delay stage lives in wr_q, so the line plus that register spans PIPE_LAT cycles
  fht_addr_delay #(.DEPTH(PIPE_LAT), .A_BIT(A_BIT)) u_wr_dly (
    .clk  (iCLK),
    .rst_n(iRESET),
    .en   (!stall),
    .d    (rd_d),
    .v_in (rd_v),
    .q    (dl_addr),
    .v_out(dl_v)
  );
  // state, counters and registered outputs
  always_ff @(posedge iCLK or negedge iRESET)
    if (!iRESET) begin
      state_q <= S_IDLE;
      k_q <= '0;
      stage_q <= '0;
      drn_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      coef_q <= '0;
      we_a_q <= 1'b0;
      we_b_q <= 1'b0;
      eof_q <= 1'b0;
      zero_q <= 1'b0;
      last_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      stage_q <= stage_d;
      drn_q <= drn_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      coef_q <= coef_d;
      we_a_q <= we_a_d;
      we_b_q <= we_b_d;
      eof_q <= eof_d;
      zero_q <= zero_d;
      last_q <= last_d;
      rdy_q <= rdy_d;
    end
  assign {oADDR_RD_3, oADDR_RD_2, oADDR_RD_1, oADDR_RD_0} = rd_q;
  assign {oADDR_WR_3, oADDR_WR_2, oADDR_WR_1, oADDR_WR_0} = wr_q;
  assign oADDR_COEF = coef_q;
  assign oSTAGE = stage_q;
  assign oST_ZERO = zero_q;
  assign oST_LAST = last_q;
  assign oEOF_READ = eof_q;
  assign oWE_A = we_a_q;
  assign oWE_B = we_b_q;
  assign oSOURCE_DATA = stage_q[0];
  assign oSOURCE_CONT = zero_q;
  assign oRDY = rdy_q;
endmodule

// File: tb/tb_fht_seq_ctrl.sv
// tb_fht_seq_ctrl: randomized bench for fht_seq_ctrl against a cycle-offset schedule model
module tb_fht_seq_ctrl;
  localparam int LOG_N = 4;
  localparam int PIPE_LAT = 2;
  localparam int A_BIT = LOG_N - 2;
  localparam int STAGES = LOG_N - 1;
  localparam int NQ = 1 << A_BIT;
  localparam int SLEN = NQ + PIPE_LAT;
  localparam int TOTAL = STAGES * SLEN;
  logic iCLK = 1'b0;
  logic iRESET, iSTART;
`ifdef FHT_CTRL_STALL_EN
  logic iSTALL;
`endif
  logic [A_BIT-1:0] rd [4];
  logic [A_BIT-1:0] wr [4];
  logic [A_BIT-1:0] coef;
  logic [1:0] stg;
  logic zero, last, eof, we_a, we_b, src, cont, rdy;
  int checks = 0;
  int errors = 0;
  int c = -1;
  bit frz = 1'b0;
  always #5 iCLK = ~iCLK;
  fht_seq_ctrl #(.LOG_N(LOG_N), .PIPE_LAT(PIPE_LAT)) dut (
    .iCLK(iCLK),
    .iRESET(iRESET),
    .iSTART(iSTART),
`ifdef FHT_CTRL_STALL_EN
    .iSTALL(iSTALL),
`endif
    .oADDR_RD_0(rd[0]),
    .oADDR_RD_1(rd[1]),
    .oADDR_RD_2(rd[2]),
    .oADDR_RD_3(rd[3]),
    .oADDR_WR_0(wr[0]),
    .oADDR_WR_1(wr[1]),
    .oADDR_WR_2(wr[2]),
    .oADDR_WR_3(wr[3]),
    .oADDR_COEF(coef),
    .oSTAGE(stg),
    .oST_ZERO(zero),
    .oST_LAST(last),
    .oEOF_READ(eof),
    .oWE_A(we_a),
    .oWE_B(we_b),
    .oSOURCE_DATA(src),
    .oSOURCE_CONT(cont),
    .oRDY(rdy)
  );
  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < A_BIT; i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction
  function automatic int rd_ref(input int s, input int k, input int b);
    if (s == 0) return brev(k);
    return b < 2 ? k : k ^ (1 << ((s - 1) % A_BIT));
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (offset %0d)", tag, obs, exp, c);
    end
  endtask
  // c is the cycle offset since the accepted start; -1 means idle
  task automatic check_outputs(input bit full);
    bit busy;
    int s, p;
    bit rv, wv;
    busy = c >= 0;
    s = busy ? c / SLEN : 0;
    p = busy ? c % SLEN : 0;
    rv = busy && p < NQ;
    wv = busy && p >= PIPE_LAT;
    check("rdy", rdy, !busy);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("rd%0d", b), rd[b], rv ? rd_ref(s, p, b) : 0);
      check($sformatf("wr%0d", b), wr[b], wv ? rd_ref(s, p - PIPE_LAT, b) : 0);
    end
    check("we_a", we_a, wv && !frz && s % 2 == 1);
    check("we_b", we_b, wv && !frz && s % 2 == 0);
    check("eof", eof, rv && p == NQ - 1 && !frz);
    check("st_zero", zero, busy && s == 0);
    check("st_last", last, busy && s == STAGES - 1);
    if (rv) check("coef", coef, s == 0 ? 0 : (p << (STAGES - 1 - s)) % NQ);
    if (busy || full) begin
      check("stage", stg, s);
      check("src_data", src, s % 2);
      check("src_cont", cont, busy && s == 0);
    end
    if (full) check("coef_rst", coef, 0);
  endtask
  task automatic tick(input bit st, input bit sl);
    bit hold;
    hold = 1'b0;
    iSTART = st;
`ifdef FHT_CTRL_STALL_EN
    iSTALL = sl;
    hold = sl && c >= 0;
`endif
    @(posedge iCLK);
    frz = hold;
    if (c < 0) c = st ? 0 : -1;
    else if (!hold) c = c + 1 == TOTAL ? -1 : c + 1;
    @(negedge iCLK);
    check_outputs(1'b0);
  endtask
  task automatic pulse_reset();
    iSTART = 1'b0;
    iRESET = 1'b0;
    c = -1;
    frz = 1'b0;
    @(posedge iCLK);
    @(negedge iCLK);
    check_outputs(1'b1);
    iRESET = 1'b1;
  endtask
  initial begin
    int n;
    iRESET = 1'b0;
    iSTART = 1'b0;
`ifdef FHT_CTRL_STALL_EN
    iSTALL = 1'b0;
`endif
    repeat (2) @(negedge iCLK);
    check_outputs(1'b1);
    iRESET = 1'b1;
    tick(0, 0);
    tick(0, 0);
    tick(1, 0);
    n = 0;
    while (!rdy && n < 40) begin
      tick(0, 0);
      n++;
    end
    check("busy_len", n, TOTAL);
    tick(1, 0);
    n = 0;
    while (!rdy && n < 40) begin
      tick(n % 3 == 0, 0);
      n++;
    end
    check("b2b_len", n, TOTAL);
    tick(1, 0);
    repeat (SLEN + 2) tick(0, 0);
    pulse_reset();
    tick(1, 0);
    n = 0;
    while (!rdy && n < 40) begin
      tick(0, 0);
      n++;
    end
    check("post_rst_len", n, TOTAL);
`ifdef FHT_CTRL_STALL_EN
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    n = 2;
    repeat (3) begin
      tick(0, 1);
      n++;
    end
    while (!rdy && n < 60) begin
      tick(0, 0);
      n++;
    end
    check("stall_len", n, TOTAL + 3);
    tick(0, 1);
    tick(1, 1);
`endif
    for (int i = 0; i < 1500; i++)
      if ($urandom_range(0, 249) == 0) pulse_reset();
      else tick($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fht_seq_ctrl.md
# fht_seq_ctrl

Parametrised FHT sequencing controller: the next-generation address/stage generator for the four-bank FHT datapath. It sits between the start/ready handshake and the butterfly pipeline. It generates read, write and coefficient addresses for four memory banks, drives the ping-pong buffer write enables and reports stage status. Transform size and butterfly pipeline latency are parameters, and stage hand-over waits for the write pipeline to drain.

## Interface
- LOG_N, 10, log2 of transform length N; legal range 4..16.
- PIPE_LAT, 4, butterfly pipeline latency in cycles, read address to write address; legal range 1..16.
- A_BIT, LOG_N-2, derived localparam: bank address width; each bank holds N/4 words.
- STAGES, LOG_N-1, derived localparam: number of stages.

Ports:
- iCLK  in  1  clock; the only clock in the block.
- iRESET  in  1  asynchronous active-low reset.
- iSTART  in  1  start pulse; sampled only in IDLE.
- iSTALL  in  1  freezes the sequencer (present only with FHT_CTRL_STALL_EN).
- oADDR_RD_0..3  out  A_BIT  bank read addresses.
- oADDR_WR_0..3  out  A_BIT  bank write addresses.
- oADDR_COEF  out  A_BIT  coefficient ROM address.
- oSTAGE  out  $clog2(STAGES)  current stage index.
- oST_ZERO  out  1  high while busy and stage==0.
- oST_LAST  out  1  high while busy and stage==STAGES-1.
- oEOF_READ  out  1  one-cycle pulse on the last read cycle of each stage.
- oWE_A, oWE_B  out  1  write enables for buffer A and buffer B.
- oSOURCE_DATA  out  1  read-buffer select: 0 selects A, 1 selects B; equals stage[0].
- oSOURCE_CONT  out  1  1 in stage 0 (raw input path), else 0.
- oRDY  out  1  1 when idle.

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE: iSTART=1 moves to READ with stage=0 and k=0. oRDY falls the next cycle.
- READ: k counts 0..N/4-1, one step per cycle. At k=N/4-1, oEOF_READ=1 and the FSM moves to DRAIN.
- DRAIN: lasts PIPE_LAT cycles. On its last cycle:
  - if stage==STAGES-1, go to IDLE;
  - otherwise increment stage, clear k and go to READ.
- Read addresses, outside READ: all 0.
- Read addresses, stage 0: all banks read bitrev(k) over A_BIT bits.
- Read addresses, stage s≥1: banks 0 and 1 read k; banks 2 and 3 read k XOR (1<<((s-1) mod A_BIT)).
- Coefficient address: stage 0 gives 0. Stage s≥1 gives (k << (STAGES-1-s)), truncated to A_BIT bits.
- Write addresses: each bank's read address delayed by exactly PIPE_LAT cycles. The delay line shifts every cycle.
- Write enable:
  - The write window is a READ cycle delayed by PIPE_LAT, so it is exactly N/4 cycles per stage.
  - Even stage: oWE_B=1 during the window. Odd stage: oWE_A=1.
  - The write enable never asserts outside a window.
- iSTART while busy is ignored; there is no queuing.
- Reset (any time, including mid-stage): state returns to IDLE immediately.
  - Outputs after reset: all addresses 0, oWE_A=oWE_B=0, oSTAGE=0, oST_ZERO=oST_LAST=0, oEOF_READ=0, oSOURCE_DATA=0, oSOURCE_CONT=0, oRDY=1.
  - The delay line clears.

## Timing
- All outputs are registered.
- Cycle 0 is the edge that samples iSTART. Cycle 1 has oRDY=0 and k=0 addresses on the read ports.
- Write address for k appears PIPE_LAT cycles after the read address for k.
- Stage length: N/4+PIPE_LAT cycles.
- Total busy time: STAGES*(N/4+PIPE_LAT) cycles. oRDY rises the cycle after the last DRAIN cycle.
- Next-stage reads start only after the last write of the previous stage, which avoids any RAW hazard across stages.
- A new start is accepted in the first IDLE cycle, so back-to-back transforms are allowed.

## Configuration
- FHT_CTRL_STALL_EN defined:
  - The iSTALL port exists.
  - iSTALL=1 freezes the FSM, k, stage and the delay line, and forces oWE_A=oWE_B=0 and oEOF_READ=0. Addresses hold their values.
  - Stall in IDLE has no effect; iSTART is still accepted.
- Not defined: the port is absent and the logic behaves as if iSTALL=0.

## Structure
- Package fht_ctrl_pkg holds:
  - the state enum;
  - the bitrev function, parametrised by width;
  - STAGES/A_BIT derivation helpers.
- One sub-module, fht_addr_delay: a PIPE_LAT-deep, 4×A_BIT-wide delay line with enable and async reset. It is instantiated once for the write addresses and carries the write-window valid bit alongside.

## Test plan
- Bench configuration: LOG_N=4, PIPE_LAT=2, so N/4=4, STAGES=3 and A_BIT=2.
- Start pulse -> stage 0 reads 0,2,1,3 on all banks. oWE_B is high for the 4 cycles starting 2 cycles after the first read, with write addresses 0,2,1,3.
- Stage 1 -> banks 2 and 3 read 1,0,3,2; banks 0 and 1 read 0,1,2,3. Coef reads 0,2,0,2. oWE_A is used and oSOURCE_DATA=1.
- Stage 2 -> banks 2 and 3 read 2,3,0,1; coef reads 0,1,2,3. oST_LAST=1, and oRDY rises exactly 18 cycles after the start was sampled.
- Reset asserted during stage 1 -> next edge shows every output at its reset value. A fresh start then runs a full 18-cycle transform.
- Start re-pulsed while busy -> ignored. Start on the first idle cycle -> a second transform runs with identical address traces.
- FHT_CTRL_STALL_EN with a 3-cycle stall at stage 0, k=2 -> addresses hold, the write enable drops, and total busy time becomes 21 cycles.
